// File: rtl/pipe_mem_wb_elastic.sv
// ---------------------------------------------------------------------------
// pipe_mem_wb_elastic
//   Elastic MEM->WB pipeline register with valid/ready handshakes on both
//   sides, flush, writeback-data mux and a saturating back-pressure counter.
//
//   Build option: define PIPE_MEM_WB_SKID_EN to add a skid entry behind the
//   head entry (registered ready_o, up to two bundles held). Without it the
//   stage is a single entry whose ready_o is combinational.
//
// Parameters
//   N   data path width of ReadData / AluResult / WBData
//   AW  destination register address width
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   valid_i/ready_o   upstream (MEM) handshake
//   ReadData_i, AluResult_i, RF_WE_i, MemWE_i, WBSelect_i, A3_i  MEM bundle
//   flush_i           discard held and incoming bundles
//   valid_o/ready_i   downstream (WB) handshake
//   ReadData_o, AluResult_o, RF_WE_o, MemWE_o, WBSelect_o, A3_o  head bundle
//   WBData_o          ReadData_o when WBSelect_o else AluResult_o
//   occupancy_o       bundles held (0..2)
//   stall_cnt_o       saturating count of cycles with valid_o && !ready_i
// ---------------------------------------------------------------------------
module pipe_mem_wb_elastic #(
   parameter int N  = 32,
   parameter int AW = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [N-1:0]  ReadData_i,
   input  logic [N-1:0]  AluResult_i,
   input  logic          RF_WE_i,
   input  logic          MemWE_i,
   input  logic          WBSelect_i,
   input  logic [AW-1:0] A3_i,
   input  logic          flush_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [N-1:0]  ReadData_o,
   output logic [N-1:0]  AluResult_o,
   output logic          RF_WE_o,
   output logic          MemWE_o,
   output logic          WBSelect_o,
   output logic [AW-1:0] A3_o,
   output logic [N-1:0]  WBData_o,
   output logic [1:0]    occupancy_o,
   output logic [15:0]   stall_cnt_o
);

   typedef struct packed {
      logic [N-1:0]  rd;
      logic [N-1:0]  alu;
      logic          rf_we;
      logic          mem_we;
      logic          wb_sel;
      logic [AW-1:0] a3;
   } bundle_t;

   bundle_t     in_b;
   bundle_t     head_q, head_d;
   logic        head_v_q, head_v_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        in_xfer, out_xfer;

`ifdef PIPE_MEM_WB_SKID_EN
   bundle_t     skid_q, skid_d;
   logic        skid_v_q, skid_v_d;
   logic        ready_q, ready_d;

   // ready_q tracks "skid empty"; it resets to 1 so the first cycle after
   // reset already accepts, and is masked while reset is held.
   assign ready_o     = ready_q & ~RST;
   assign occupancy_o = {1'b0, head_v_q} + {1'b0, skid_v_q};
`else
   assign ready_o     = ~RST & (~head_v_q | ready_i);
   assign occupancy_o = {1'b0, head_v_q};
`endif

   assign in_b     = '{rd: ReadData_i, alu: AluResult_i, rf_we: RF_WE_i,
                       mem_we: MemWE_i, wb_sel: WBSelect_i, a3: A3_i};
   assign in_xfer  = valid_i & ready_o;
   assign out_xfer = head_v_q & ready_i;

   always_comb begin
      head_d      = head_q;
      head_v_d    = head_v_q;
      stall_cnt_d = stall_cnt_q;
`ifdef PIPE_MEM_WB_SKID_EN
      skid_d      = skid_q;
      skid_v_d    = skid_v_q;
`endif

      if (flush_i) begin
         // Only the valid bits drop; data registers keep their last values.
         head_v_d = 1'b0;
`ifdef PIPE_MEM_WB_SKID_EN
         skid_v_d = 1'b0;
`endif
      end else begin
`ifdef PIPE_MEM_WB_SKID_EN
         // An input can never arrive while the skid entry is full, because
         // ready_o is low exactly then.
         if (out_xfer) begin
            if (skid_v_q) begin
               head_d   = skid_q;
               skid_v_d = 1'b0;
            end else if (in_xfer) begin
               head_d   = in_b;
            end else begin
               head_v_d = 1'b0;
            end
         end else if (in_xfer) begin
            if (head_v_q) begin
               skid_d   = in_b;
               skid_v_d = 1'b1;
            end else begin
               head_d   = in_b;
               head_v_d = 1'b1;
            end
         end
`else
         if (in_xfer) begin
            head_d   = in_b;
            head_v_d = 1'b1;
         end else if (out_xfer) begin
            head_v_d = 1'b0;
         end
`endif
      end

`ifdef PIPE_MEM_WB_SKID_EN
      ready_d = ~skid_v_d;
`endif

      if (head_v_q && !ready_i && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         head_q      <= '0;
         head_v_q    <= 1'b0;
         stall_cnt_q <= '0;
`ifdef PIPE_MEM_WB_SKID_EN
         skid_q      <= '0;
         skid_v_q    <= 1'b0;
         ready_q     <= 1'b1;
`endif
      end else begin
         head_q      <= head_d;
         head_v_q    <= head_v_d;
         stall_cnt_q <= stall_cnt_d;
`ifdef PIPE_MEM_WB_SKID_EN
         skid_q      <= skid_d;
         skid_v_q    <= skid_v_d;
         ready_q     <= ready_d;
`endif
      end
   end

   assign valid_o     = head_v_q;
   assign ReadData_o  = head_q.rd;
   assign AluResult_o = head_q.alu;
   assign WBSelect_o  = head_q.wb_sel;
   assign A3_o        = head_q.a3;
   // Enables are qualified so a stale stored bit never leaks out.
   assign RF_WE_o     = head_q.rf_we  & head_v_q;
   assign MemWE_o     = head_q.mem_we & head_v_q;
   assign WBData_o    = head_q.wb_sel ? head_q.rd : head_q.alu;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_mem_wb_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_mem_wb_elastic
//   Directed bench for pipe_mem_wb_elastic (N=32, AW=4). A queue-based model
//   of the stage is compared with the DUT on every falling edge; literal
//   expectations at key points pin the model. Works with or without
//   PIPE_MEM_WB_SKID_EN defined.
// ---------------------------------------------------------------------------
module tb_pipe_mem_wb_elastic;

   typedef struct packed {
      logic [31:0] rd;
      logic [31:0] alu;
      logic        rf_we;
      logic        mem_we;
      logic        wb_sel;
      logic [3:0]  a3;
   } bun_t;

   logic        CLK = 1'b0;
   logic        RST, valid_i, ready_o, RF_WE_i, MemWE_i, WBSelect_i, flush_i;
   logic        valid_o, ready_i, RF_WE_o, MemWE_o, WBSelect_o;
   logic [31:0] ReadData_i, AluResult_i, ReadData_o, AluResult_o, WBData_o;
   logic [3:0]  A3_i, A3_o;
   logic [1:0]  occupancy_o;
   logic [15:0] stall_cnt_o;

   int checks = 0;
   int errors = 0;
   int printed = 0;

   pipe_mem_wb_elastic #(.N(32), .AW(4)) dut (
      .CLK(CLK), .RST(RST), .valid_i(valid_i), .ready_o(ready_o),
      .ReadData_i(ReadData_i), .AluResult_i(AluResult_i),
      .RF_WE_i(RF_WE_i), .MemWE_i(MemWE_i), .WBSelect_i(WBSelect_i),
      .A3_i(A3_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
      .ReadData_o(ReadData_o), .AluResult_o(AluResult_o),
      .RF_WE_o(RF_WE_o), .MemWE_o(MemWE_o), .WBSelect_o(WBSelect_o),
      .A3_o(A3_o), .WBData_o(WBData_o), .occupancy_o(occupancy_o),
      .stall_cnt_o(stall_cnt_o)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (printed < 40) begin
            printed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
         end
      end
   endtask

   // ---------------- behavioural model ----------------
   bun_t        mq[$];
   bun_t        shown;
   int unsigned m_stall;
   bit          m_known = 1'b0;

   function automatic bit m_ready();
`ifdef PIPE_MEM_WB_SKID_EN
      return !RST && (mq.size() < 2);
`else
      return !RST && (mq.size() == 0 || ready_i);
`endif
   endfunction

   always @(posedge CLK) begin : model_upd
      bit   in_x, out_x;
      bun_t nb;
      in_x  = valid_i && m_ready();
      out_x = (mq.size() > 0) && ready_i;
      nb    = '{ReadData_i, AluResult_i, RF_WE_i, MemWE_i, WBSelect_i, A3_i};
      if (RST) begin
         mq.delete();
         shown   = '0;
         m_stall = 0;
         m_known = 1'b1;
      end else begin
         if (mq.size() > 0 && !ready_i && m_stall < 65535) m_stall++;
         if (flush_i) mq.delete();
         else begin
            if (out_x) void'(mq.pop_front());
            if (in_x)  mq.push_back(nb);
         end
         if (mq.size() > 0) shown = mq[0];
      end
   end

   // DUT-side record of delivered destination addresses
   int dlv[$];

   always @(negedge CLK) begin : compare
      bit v;
      if (m_known) begin
         v = mq.size() > 0;
         chk("valid_o",     {31'd0, valid_o},     {31'd0, v});
         chk("ready_o",     {31'd0, ready_o},     {31'd0, m_ready()});
         chk("occupancy_o", {30'd0, occupancy_o}, mq.size());
         chk("stall_cnt_o", {16'd0, stall_cnt_o}, m_stall);
         chk("ReadData_o",  ReadData_o,           shown.rd);
         chk("AluResult_o", AluResult_o,          shown.alu);
         chk("WBSelect_o",  {31'd0, WBSelect_o},  {31'd0, shown.wb_sel});
         chk("A3_o",        {28'd0, A3_o},        {28'd0, shown.a3});
         chk("RF_WE_o",     {31'd0, RF_WE_o},     {31'd0, shown.rf_we & v});
         chk("MemWE_o",     {31'd0, MemWE_o},     {31'd0, shown.mem_we & v});
         chk("WBData_o",    WBData_o,             shown.wb_sel ? shown.rd : shown.alu);
      end
      if (valid_o && ready_i && !RST && !flush_i) dlv.push_back(int'(A3_o));
   end

   // ---------------- stimulus helpers ----------------
   bun_t src[$];
   bit   acc;

   function automatic bun_t mk(input logic [31:0] rd, input logic [31:0] alu,
                               input bit rfwe, input bit mwe, input bit wbs,
                               input logic [3:0] a3);
      return '{rd, alu, rfwe, mwe, wbs, a3};
   endfunction

   task automatic present();
      if (src.size() > 0) begin
         valid_i     = 1'b1;
         ReadData_i  = src[0].rd;
         AluResult_i = src[0].alu;
         RF_WE_i     = src[0].rf_we;
         MemWE_i     = src[0].mem_we;
         WBSelect_i  = src[0].wb_sel;
         A3_i        = src[0].a3;
      end else begin
         valid_i = 1'b0;
      end
   endtask

   task automatic tick();
      #1;
      acc = valid_i && ready_o;
      @(posedge CLK);
      #2;
   endtask

   task automatic run(input int n, input bit rdy, input bit alt);
      for (int i = 0; i < n; i++) begin
         ready_i = alt ? ((i % 3) != 0) : rdy;
         present();
         tick();
         if (acc && src.size() > 0) void'(src.pop_front());
      end
      present();
   endtask

   int exp_ord[3] = '{5, 6, 7};

   initial begin
      RST = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
      ReadData_i = '0; AluResult_i = '0; RF_WE_i = 1'b0; MemWE_i = 1'b0;
      WBSelect_i = 1'b0; A3_i = '0;

      // reset
      tick();
      chk("rst_ready_o", {31'd0, ready_o}, 32'd0);
      chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
      chk("rst_occ",     {30'd0, occupancy_o}, 32'd0);
      chk("rst_stall",   {16'd0, stall_cnt_o}, 32'd0);
      RST = 1'b0;
      #1;
      chk("post_rst_ready_o", {31'd0, ready_o}, 32'd1);

      // single ALU bundle
      src.push_back(mk(32'h0, 32'h0000_0010, 1, 0, 0, 4'd3));
      run(1, 1, 0);
      chk("single_valid_o", {31'd0, valid_o}, 32'd1);
      chk("single_WBData",  WBData_o, 32'h0000_0010);
      chk("single_RF_WE",   {31'd0, RF_WE_o}, 32'd1);
      chk("single_A3",      {28'd0, A3_o}, 32'd3);
      run(1, 1, 0);
      chk("drained_valid_o", {31'd0, valid_o}, 32'd0);
      chk("drained_RF_WE",   {31'd0, RF_WE_o}, 32'd0);
      chk("drained_A3_hold", {28'd0, A3_o}, 32'd3);

      // load writeback
      src.push_back(mk(32'hDEAD_BEEF, 32'h0000_0100, 1, 0, 1, 4'd9));
      run(1, 1, 0);
      chk("load_WBData", WBData_o, 32'hDEAD_BEEF);
      run(1, 1, 0);

      // streaming, then a ready pattern with gaps
      src.push_back(mk(32'h1111_1111, 32'h2222_2222, 1, 0, 1, 4'd1));
      src.push_back(mk(32'h3333_3333, 32'h4444_4444, 0, 1, 0, 4'd2));
      src.push_back(mk(32'h5555_5555, 32'h6666_6666, 1, 1, 1, 4'd4));
      src.push_back(mk(32'h7777_7777, 32'h8888_8888, 0, 0, 0, 4'd8));
      run(6, 1, 0);
      for (int k = 0; k < 6; k++)
         src.push_back(mk(32'hA000_0000 + k, 32'hB000_0000 + k, k[0], k[1], k[0], 4'(k + 10)));
      run(16, 1, 1);

      // back-pressure with A, B, C
      dlv.delete();
      src.push_back(mk(32'hA, 32'h1A, 1, 0, 0, 4'd5));
      src.push_back(mk(32'hB, 32'h1B, 1, 0, 1, 4'd6));
      src.push_back(mk(32'hC, 32'h1C, 0, 1, 0, 4'd7));
      run(3, 0, 0);
`ifdef PIPE_MEM_WB_SKID_EN
      chk("bp_occ", {30'd0, occupancy_o}, 32'd2);
`else
      chk("bp_occ", {30'd0, occupancy_o}, 32'd1);
`endif
      chk("bp_ready_o", {31'd0, ready_o}, 32'd0);
      chk("bp_head_A3", {28'd0, A3_o}, 32'd5);
      run(8, 1, 0);
      chk("bp_count", dlv.size(), 32'd3);
      for (int k = 0; k < 3; k++)
         chk("bp_order", (k < dlv.size()) ? dlv[k] : 32'hFFFF, exp_ord[k]);

      // flush with a simultaneous incoming bundle
      src.push_back(mk(32'hD, 32'h1D, 1, 1, 0, 4'd12));
      src.push_back(mk(32'hE, 32'h1E, 1, 1, 0, 4'd13));
      run(2, 0, 0);
      src.delete();
      src.push_back(mk(32'hF, 32'h1F, 1, 1, 1, 4'd14));
      present();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      src.delete();
      present();
      chk("flush_valid_o", {31'd0, valid_o}, 32'd0);
      chk("flush_occ",     {30'd0, occupancy_o}, 32'd0);
      chk("flush_RF_WE",   {31'd0, RF_WE_o}, 32'd0);
      #1;
      chk("flush_ready_o", {31'd0, ready_o}, 32'd1);
      dlv.delete();
      run(3, 1, 0);
      chk("flush_no_out", dlv.size(), 32'd0);

      // reset in the middle of back-pressure
      src.push_back(mk(32'h21, 32'h31, 1, 1, 1, 4'd11));
      src.push_back(mk(32'h22, 32'h32, 1, 0, 0, 4'd12));
      src.push_back(mk(32'h23, 32'h33, 1, 0, 0, 4'd13));
      run(2, 0, 0);
      RST = 1'b1;
      #1;
      chk("mid_rst_ready_o", {31'd0, ready_o}, 32'd0);
      tick();
      chk("mid_rst_valid_o",  {31'd0, valid_o}, 32'd0);
      chk("mid_rst_occ",      {30'd0, occupancy_o}, 32'd0);
      chk("mid_rst_ReadData", ReadData_o, 32'd0);
      chk("mid_rst_A3",       {28'd0, A3_o}, 32'd0);
      chk("mid_rst_ready_in", {31'd0, ready_o}, 32'd0);
      RST = 1'b0;
      src.delete();
      present();
      #1;
      chk("mid_rst_ready_after", {31'd0, ready_o}, 32'd1);

      // stall counter: 5 cycles, then saturation
      src.push_back(mk(32'h55, 32'h66, 1, 0, 0, 4'd15));
      run(1, 0, 0);
      run(5, 0, 0);
      chk("stall_5", {16'd0, stall_cnt_o}, 32'd5);
      repeat (70000) tick();
      chk("stall_sat", {16'd0, stall_cnt_o}, 32'h0000_FFFF);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("stall_kept_by_flush", {16'd0, stall_cnt_o}, 32'h0000_FFFF);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
